// File: rtl/rf_scoreboard_if.sv
// Register-file / scoreboard bus: read ports, write port, reservation handshake
// and hazard status.
// master: requester side (drives indices, write and reservation requests)
// slave : rf_scoreboard side (returns read data, ready, busy, stall, pend_cnt)
interface rf_scoreboard_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic [AW-1:0]   rR1;
  logic [AW-1:0]   rR2;
  logic [XLEN-1:0] rD1;
  logic [XLEN-1:0] rD2;
  logic            rf_we;
  logic [AW-1:0]   wR;
  logic [XLEN-1:0] wD;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_rd;
  logic            rsv_ready;
  logic            busy1;
  logic            busy2;
  logic            stall;
  logic [AW:0]     pend_cnt;

  modport master (
    output rR1, rR2, rf_we, wR, wD, rsv_valid, rsv_rd,
    input  rD1, rD2, rsv_ready, busy1, busy2, stall, pend_cnt
  );

  modport slave (
    input  rR1, rR2, rf_we, wR, wD, rsv_valid, rsv_rd,
    output rD1, rD2, rsv_ready, busy1, busy2, stall, pend_cnt
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Register file (2 read, 1 write) with a per-register pending-write scoreboard.
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - rf_scoreboard_if.slave: rR1/rR2 -> rD1/rD2 (combinational reads),
//           rf_we/wR/wD write port, rsv_valid/rsv_rd/rsv_ready reservation
//           handshake, busy1/busy2/stall hazard flags, pend_cnt pending count.
// Optional feature macro: RF_BYPASS_EN -- forwards same-cycle write data to the
// read ports and hides the busy flag of a register being written this cycle.
module rf_scoreboard #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input logic            clk,
  input logic            rst_n,
  rf_scoreboard_if.slave bus
);
  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned CW   = AW + 1;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   cnt;
  logic            set_fire;
  logic            clr_fire;
  logic            same_idx;
  logic            hit1;
  logic            hit2;

  // A busy destination may be re-reserved only when its pending write retires now.
  assign bus.rsv_ready = ~busy[bus.rsv_rd] | (bus.rf_we & (bus.wR == bus.rsv_rd));

  assign set_fire = bus.rsv_valid & bus.rsv_ready & (bus.rsv_rd != '0);
  assign clr_fire = bus.rf_we & (bus.wR != '0) & busy[bus.wR];
  // Retire and re-reserve of one register: it stays pending, count unchanged.
  assign same_idx = set_fire & clr_fire & (bus.wR == bus.rsv_rd);

  // Clear first, then set, so a new reservation wins over a same-cycle retire.
  always_comb begin
    busy_nxt = busy;
    if (bus.rf_we) busy_nxt[bus.wR] = 1'b0;
    if (set_fire) busy_nxt[bus.rsv_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard state and pending count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      unique case ({set_fire & ~same_idx, clr_fire & ~same_idx})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Register storage; index 0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[AW'(i)] <= '0;
    end else if (bus.rf_we && (bus.wR != '0)) begin
      regs[bus.wR] <= bus.wD;
    end
  end

`ifdef RF_BYPASS_EN
  // Forwarding is gated by rst_n so reads stay zero throughout reset.
  assign hit1 = rst_n & bus.rf_we & (bus.wR == bus.rR1) & (bus.rR1 != '0);
  assign hit2 = rst_n & bus.rf_we & (bus.wR == bus.rR2) & (bus.rR2 != '0);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign bus.rD1      = hit1 ? bus.wD : regs[bus.rR1];
  assign bus.rD2      = hit2 ? bus.wD : regs[bus.rR2];
  assign bus.busy1    = busy[bus.rR1] & ~hit1;
  assign bus.busy2    = busy[bus.rR2] & ~hit2;
  assign bus.stall    = bus.busy1 | bus.busy2 | (bus.rsv_valid & ~bus.rsv_ready);
  assign bus.pend_cnt = cnt;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios plus a random
// phase checked against a behavioural model, expectations queued at drive time.
module tb_rf_scoreboard;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [63:0] exp_q[$];
  logic [63:0] exp;

  rf_scoreboard_if #(.XLEN(XLEN), .AW(AW)) bus ();

  rf_scoreboard #(.XLEN(XLEN), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rR1       = '0;
    bus.rR2       = '0;
    bus.rf_we     = 1'b0;
    bus.wR        = '0;
    bus.wD        = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_rd    = '0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.rR1       = 5'd5;
    bus.rR2       = 5'd5;
    bus.rf_we     = 1'b1;
    bus.wR        = 5'd5;
    bus.wD        = 32'hFFFF_FFFF;
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = 5'd5;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd1);
    exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    repeat (2) @(posedge clk);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD1 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL reset_rd1: got %h expected %h", bus.rD1, exp[XLEN-1:0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.stall !== exp[0]) begin n_fail++; $display("FAIL reset_stall: got %b expected %b", bus.stall, exp[0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rsv_ready !== exp[0]) begin n_fail++; $display("FAIL reset_ready: got %b expected %b", bus.rsv_ready, exp[0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.pend_cnt !== exp[AW:0]) begin n_fail++; $display("FAIL reset_pend: got %0d expected %0d", bus.pend_cnt, exp[AW:0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy1 !== exp[0]) begin n_fail++; $display("FAIL reset_busy1: got %b expected %b", bus.busy1, exp[0]); end
    idle();
    bus.rR1 = 5'd5;
    #1 rst_n = 1'b1;
    cyc();
    exp_q.push_back(64'd0);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD1 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL reset_write_discarded: got %h expected %h", bus.rD1, exp[XLEN-1:0]); end
  endtask

  task automatic test_write();
    cyc();
    idle();
    bus.rf_we = 1'b1; bus.wR = 5'd5; bus.wD = 32'hDEAD_BEEF;
    cyc();
    idle();
    bus.rR1 = 5'd5; bus.rR2 = 5'd5;
    exp_q.push_back(64'hDEAD_BEEF); exp_q.push_back(64'hDEAD_BEEF);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD1 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL write_rd1: got %h expected %h", bus.rD1, exp[XLEN-1:0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD2 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL write_rd2: got %h expected %h", bus.rD2, exp[XLEN-1:0]); end
    cyc();
    idle();
    bus.rf_we = 1'b1; bus.wR = 5'd0; bus.wD = 32'h1;
    exp_q.push_back(64'd0);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD1 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL r0_same_cycle: got %h expected %h", bus.rD1, exp[XLEN-1:0]); end
    cyc();
    idle();
    exp_q.push_back(64'd0);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD1 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL r0_after_write: got %h expected %h", bus.rD1, exp[XLEN-1:0]); end
  endtask

  task automatic test_reserve();
    cyc();
    idle();
    bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd7;
    exp_q.push_back(64'd1);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rsv_ready !== exp[0]) begin n_fail++; $display("FAIL rsv_ready_free: got %b expected %b", bus.rsv_ready, exp[0]); end
    cyc();
    idle();
    bus.rR2 = 5'd7;
    exp_q.push_back(64'd1); exp_q.push_back(64'd1); exp_q.push_back(64'd1);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy2 !== exp[0]) begin n_fail++; $display("FAIL rsv_busy2: got %b expected %b", bus.busy2, exp[0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.stall !== exp[0]) begin n_fail++; $display("FAIL rsv_stall: got %b expected %b", bus.stall, exp[0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.pend_cnt !== exp[AW:0]) begin n_fail++; $display("FAIL rsv_pend1: got %0d expected %0d", bus.pend_cnt, exp[AW:0]); end
    bus.rf_we = 1'b1; bus.wR = 5'd7; bus.wD = 32'h77;
    cyc();
    idle();
    bus.rR2 = 5'd7;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'h77);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy2 !== exp[0]) begin n_fail++; $display("FAIL retire_busy2: got %b expected %b", bus.busy2, exp[0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.pend_cnt !== exp[AW:0]) begin n_fail++; $display("FAIL retire_pend0: got %0d expected %0d", bus.pend_cnt, exp[AW:0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD2 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL retire_rd2: got %h expected %h", bus.rD2, exp[XLEN-1:0]); end
  endtask

  task automatic test_refuse();
    cyc();
    idle();
    bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd7;
    cyc();
    idle();
    bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd7;
    exp_q.push_back(64'd0); exp_q.push_back(64'd1);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rsv_ready !== exp[0]) begin n_fail++; $display("FAIL refuse_ready: got %b expected %b", bus.rsv_ready, exp[0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.stall !== exp[0]) begin n_fail++; $display("FAIL refuse_stall: got %b expected %b", bus.stall, exp[0]); end
    cyc();
    idle();
    exp_q.push_back(64'd1);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.pend_cnt !== exp[AW:0]) begin n_fail++; $display("FAIL refuse_pend: got %0d expected %0d", bus.pend_cnt, exp[AW:0]); end
    bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd7;
    bus.rf_we = 1'b1; bus.wR = 5'd7; bus.wD = 32'h70;
    exp_q.push_back(64'd1); exp_q.push_back(64'd0);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rsv_ready !== exp[0]) begin n_fail++; $display("FAIL rereserve_ready: got %b expected %b", bus.rsv_ready, exp[0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.stall !== exp[0]) begin n_fail++; $display("FAIL rereserve_stall: got %b expected %b", bus.stall, exp[0]); end
    cyc();
    idle();
    bus.rR1 = 5'd7;
    exp_q.push_back(64'd1); exp_q.push_back(64'd1); exp_q.push_back(64'h70);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy1 !== exp[0]) begin n_fail++; $display("FAIL rereserve_busy1: got %b expected %b", bus.busy1, exp[0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.pend_cnt !== exp[AW:0]) begin n_fail++; $display("FAIL rereserve_pend: got %0d expected %0d", bus.pend_cnt, exp[AW:0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD1 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL rereserve_rd1: got %h expected %h", bus.rD1, exp[XLEN-1:0]); end
    bus.rf_we = 1'b1; bus.wR = 5'd7; bus.wD = 32'h77;
    cyc();
    idle();
  endtask

  task automatic test_bypass();
    bus.rf_we = 1'b1; bus.wR = 5'd3; bus.wD = 32'h33;
    cyc();
    idle();
    bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd3;
    cyc();
    idle();
    bus.rf_we = 1'b1; bus.wR = 5'd3; bus.wD = 32'h55; bus.rR1 = 5'd3;
`ifdef RF_BYPASS_EN
    exp_q.push_back(64'h55); exp_q.push_back(64'd0);
`else
    exp_q.push_back(64'h33); exp_q.push_back(64'd1);
`endif
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD1 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL bypass_rd1: got %h expected %h", bus.rD1, exp[XLEN-1:0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy1 !== exp[0]) begin n_fail++; $display("FAIL bypass_busy1: got %b expected %b", bus.busy1, exp[0]); end
    cyc();
    idle();
    bus.rR1 = 5'd3;
    exp_q.push_back(64'h55); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    #2;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD1 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL bypass_after_rd1: got %h expected %h", bus.rD1, exp[XLEN-1:0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy1 !== exp[0]) begin n_fail++; $display("FAIL bypass_after_busy1: got %b expected %b", bus.busy1, exp[0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.pend_cnt !== exp[AW:0]) begin n_fail++; $display("FAIL bypass_after_pend: got %0d expected %0d", bus.pend_cnt, exp[AW:0]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 32; i++) begin
      cyc();
      idle();
      bus.rsv_valid = 1'b1; bus.rsv_rd = AW'(i);
    end
    cyc();
    idle();
    bus.rR1 = 5'd5; bus.rR2 = 5'd7;
    exp_q.push_back(64'd31); exp_q.push_back(64'd1);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.pend_cnt !== exp[AW:0]) begin n_fail++; $display("FAIL fill_pend31: got %0d expected %0d", bus.pend_cnt, exp[AW:0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.stall !== exp[0]) begin n_fail++; $display("FAIL fill_stall: got %b expected %b", bus.stall, exp[0]); end
    bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd9;
    #1 rst_n = 1'b0;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    exp_q.push_back(64'd0); exp_q.push_back(64'd1);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.pend_cnt !== exp[AW:0]) begin n_fail++; $display("FAIL async_rst_pend: got %0d expected %0d", bus.pend_cnt, exp[AW:0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD1 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL async_rst_rd1: got %h expected %h", bus.rD1, exp[XLEN-1:0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rD2 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL async_rst_rd2: got %h expected %h", bus.rD2, exp[XLEN-1:0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.stall !== exp[0]) begin n_fail++; $display("FAIL async_rst_stall: got %b expected %b", bus.stall, exp[0]); end
    exp = exp_q.pop_front(); n_chk++;
    if (bus.rsv_ready !== exp[0]) begin n_fail++; $display("FAIL async_rst_ready: got %b expected %b", bus.rsv_ready, exp[0]); end
    cyc();
    idle();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [XLEN-1:0] mr [32];
    logic            mb [32];
    int              mc;
    logic            rdy;
    logic            set;
    for (int i = 0; i < 32; i++) begin mr[i] = '0; mb[i] = 1'b0; end
    mc = 0;
    for (int n = 0; n < 300; n++) begin
      cyc();
      bus.rR1       = AW'($urandom_range(0, 7));
      bus.rR2       = AW'($urandom_range(0, 7));
      bus.rf_we     = ($urandom_range(0, 9) < 4);
      bus.wR        = AW'($urandom_range(0, 7));
      bus.wD        = $urandom;
      bus.rsv_valid = ($urandom_range(0, 1) == 1);
      bus.rsv_rd    = AW'($urandom_range(0, 7));
      rdy = !mb[bus.rsv_rd] || (bus.rf_we && (bus.wR == bus.rsv_rd));
`ifdef RF_BYPASS_EN
      exp_q.push_back((bus.rf_we && bus.wR == bus.rR1 && bus.rR1 != 0) ? 64'(bus.wD) : 64'(mr[bus.rR1]));
      exp_q.push_back(64'(mb[bus.rR1] && !(bus.rf_we && bus.wR == bus.rR1)));
`else
      exp_q.push_back(64'(mr[bus.rR1]));
      exp_q.push_back(64'(mb[bus.rR1]));
`endif
      exp_q.push_back(64'(rdy));
      exp_q.push_back(64'(mc));
      #2;
      exp = exp_q.pop_front(); n_chk++;
      if (bus.rD1 !== exp[XLEN-1:0]) begin n_fail++; $display("FAIL rand_rd1 @%0d: got %h expected %h", n, bus.rD1, exp[XLEN-1:0]); end
      exp = exp_q.pop_front(); n_chk++;
      if (bus.busy1 !== exp[0]) begin n_fail++; $display("FAIL rand_busy1 @%0d: got %b expected %b", n, bus.busy1, exp[0]); end
      exp = exp_q.pop_front(); n_chk++;
      if (bus.rsv_ready !== exp[0]) begin n_fail++; $display("FAIL rand_ready @%0d: got %b expected %b", n, bus.rsv_ready, exp[0]); end
      exp = exp_q.pop_front(); n_chk++;
      if (bus.pend_cnt !== exp[AW:0]) begin n_fail++; $display("FAIL rand_pend @%0d: got %0d expected %0d", n, bus.pend_cnt, exp[AW:0]); end
      // Model update: retire first, then reserve.
      set = bus.rsv_valid && rdy && (bus.rsv_rd != 0);
      if (bus.rf_we && bus.wR != 0) begin
        mr[bus.wR] = bus.wD;
        if (mb[bus.wR]) mc--;
        mb[bus.wR] = 1'b0;
      end
      if (set) begin
        if (!mb[bus.rsv_rd]) mc++;
        mb[bus.rsv_rd] = 1'b1;
      end
    end
    cyc();
    idle();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    test_reset();
    test_write();
    test_reserve();
    test_refuse();
    test_bypass();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
